// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: round-robin between plotter and cursor, plus a full-frame clear sweep.
// Optional macro FB_ARB_DROP_CNT_EN adds o_drop_count, a saturating count of out-of-range drops.
module fb_write_arbiter #(
  parameter int         X_MAX       = 639,
  parameter int         Y_MAX       = 479,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear_req,
  output logic        o_clear_busy,
  input  logic        i_p_valid,
  output logic        o_p_ready,
  input  logic [9:0]  i_p_x,
  input  logic [8:0]  i_p_y,
  input  logic [2:0]  i_p_color,
  input  logic        i_c_valid,
  output logic        o_c_ready,
  input  logic [9:0]  i_c_x,
  input  logic [8:0]  i_c_y,
  input  logic [2:0]  i_c_color,
  output logic        o_we,
  output logic [18:0] o_addr,
  output logic [2:0]  o_data
`ifdef FB_ARB_DROP_CNT_EN
  ,
  output logic [15:0] o_drop_count
`endif
);

  localparam logic [9:0] X_LAST = X_MAX[9:0];
  localparam logic [8:0] Y_LAST = Y_MAX[8:0];

  typedef enum logic {ARB, CLEAR} state_t;

  state_t      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;   // 0: plotter wins a tie, 1: cursor wins
  logic [9:0]  cx_q, cx_d;
  logic [8:0]  cy_q, cy_d;
  logic        busy_d;
  logic        we_d;
  logic [18:0] addr_d;
  logic [2:0]  data_d;

  function automatic logic in_range(input logic [9:0] x, input logic [8:0] y);
    return (x <= X_LAST) && (y <= Y_LAST);
  endfunction

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    busy_d    = o_clear_busy;
    we_d      = 1'b0;
    addr_d    = o_addr;
    data_d    = o_data;
    o_p_ready = 1'b0;
    o_c_ready = 1'b0;
    case (state_q)
      ARB: begin
        if (!i_rst_n) begin
          state_d = ARB;
        end else if (i_clear_req) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
        end else begin
          o_p_ready = i_p_valid && (!i_c_valid || !rr_ptr_q);
          o_c_ready = i_c_valid && (!i_p_valid ||  rr_ptr_q);
          // Out-of-range pixels are still handshaken so the source never stalls.
          if (o_p_ready) begin
            rr_ptr_d = 1'b1;
            if (in_range(i_p_x, i_p_y)) begin
              we_d   = 1'b1;
              addr_d = {i_p_x, i_p_y};
              data_d = i_p_color;
            end
          end else if (o_c_ready) begin
            rr_ptr_d = 1'b0;
            if (in_range(i_c_x, i_c_y)) begin
              we_d   = 1'b1;
              addr_d = {i_c_x, i_c_y};
              data_d = i_c_color;
            end
          end
        end
      end
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = {cx_q, cy_q};
        data_d = CLEAR_COLOR;
        if (cy_q == Y_LAST) begin
          cy_d = '0;
          if (cx_q == X_LAST) begin
            cx_d    = '0;
            state_d = ARB;
            busy_d  = 1'b0;
          end else begin
            cx_d = cx_q + 10'd1;
          end
        end else begin
          cy_d = cy_q + 9'd1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Registered write port stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ARB;
      rr_ptr_q     <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      o_clear_busy <= 1'b0;
      o_we         <= 1'b0;
      o_addr       <= '0;
      o_data       <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      o_clear_busy <= busy_d;
      o_we         <= we_d;
      o_addr       <= addr_d;
      o_data       <= data_d;
    end
  end

`ifdef FB_ARB_DROP_CNT_EN
  logic drop_evt;
  assign drop_evt = (o_p_ready || o_c_ready) && !we_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop_count <= '0;
    end else if (drop_evt && (o_drop_count != 16'hFFFF)) begin
      o_drop_count <= o_drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: a full-size instance for handshake/range tests and a
// 4x2 instance for clear-sweep and reset-abort tests.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_b, clr_s;
  logic        p_valid, c_valid;
  logic [9:0]  p_x, c_x;
  logic [8:0]  p_y, c_y;
  logic [2:0]  p_col, c_col;

  logic        b_busy, b_pr, b_cr, b_we;
  logic [18:0] b_addr;
  logic [2:0]  b_data;
  logic        s_busy, s_pr, s_cr, s_we;
  logic [18:0] s_addr;
  logic [2:0]  s_data;
`ifdef FB_ARB_DROP_CNT_EN
  logic [15:0] b_drops, s_drops;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fb_write_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear_req(clr_b), .o_clear_busy(b_busy),
    .i_p_valid(p_valid), .o_p_ready(b_pr), .i_p_x(p_x), .i_p_y(p_y), .i_p_color(p_col),
    .i_c_valid(c_valid), .o_c_ready(b_cr), .i_c_x(c_x), .i_c_y(c_y), .i_c_color(c_col),
    .o_we(b_we), .o_addr(b_addr), .o_data(b_data)
`ifdef FB_ARB_DROP_CNT_EN
    , .o_drop_count(b_drops)
`endif
  );

  fb_write_arbiter #(.X_MAX(3), .Y_MAX(1), .CLEAR_COLOR(3'b000)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear_req(clr_s), .o_clear_busy(s_busy),
    .i_p_valid(p_valid), .o_p_ready(s_pr), .i_p_x(p_x), .i_p_y(p_y), .i_p_color(p_col),
    .i_c_valid(c_valid), .o_c_ready(s_cr), .i_c_x(c_x), .i_c_y(c_y), .i_c_color(c_col),
    .o_we(s_we), .o_addr(s_addr), .o_data(s_data)
`ifdef FB_ARB_DROP_CNT_EN
    , .o_drop_count(s_drops)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fa(input int x, input int y);
    logic [18:0] a;
    a = {x[9:0], y[8:0]};
    return 32'(a);
  endfunction

  initial begin
    rst_n = 1'b0; clr_b = 1'b0; clr_s = 1'b0;
    p_valid = 1'b1; c_valid = 1'b1;
    p_x = 10'd5; p_y = 9'd7; p_col = 3'd5;
    c_x = 10'd3; c_y = 9'd4; c_col = 3'd2;

    // reset state, readies held low with valids asserted
    #12;
    chk("rst_we",    32'(b_we), 32'd0);
    chk("rst_addr",  32'(b_addr), 32'd0);
    chk("rst_data",  32'(b_data), 32'd0);
    chk("rst_busy",  32'(b_busy), 32'd0);
    chk("rst_pready", 32'(b_pr), 32'd0);
    chk("rst_cready", 32'(b_cr), 32'd0);
`ifdef FB_ARB_DROP_CNT_EN
    chk("rst_drops", 32'(b_drops), 32'd0);
`endif
    p_valid = 1'b0; c_valid = 1'b0;
    step();
    rst_n = 1'b1;

    // single plotter write
    step();
    p_valid = 1'b1; p_x = 10'd5; p_y = 9'd7; p_col = 3'b101;
    #1;
    chk("single_pready", 32'(b_pr), 32'd1);
    chk("single_cready", 32'(b_cr), 32'd0);
    step();
    chk("single_we",   32'(b_we), 32'd1);
    chk("single_addr", 32'(b_addr), 32'h00A07);
    chk("single_data", 32'(b_data), 32'd5);
    p_valid = 1'b0;
    step();
    chk("idle_we",   32'(b_we), 32'd0);
    chk("idle_addr", 32'(b_addr), 32'h00A07);
    chk("idle_data", 32'(b_data), 32'd5);

    // round robin from fresh reset: P, C, P, C
    rst_n = 1'b0; #1; rst_n = 1'b1;
    p_valid = 1'b1; p_x = 10'd1; p_y = 9'd2; p_col = 3'd1;
    c_valid = 1'b1; c_x = 10'd3; c_y = 9'd4; c_col = 3'd2;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_pready", 32'(b_pr), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_cready", 32'(b_cr), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk("rr_we",   32'(b_we), 32'd1);
      chk("rr_addr", 32'(b_addr), (i % 2 == 0) ? fa(1, 2) : fa(3, 4));
      chk("rr_data", 32'(b_data), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    p_valid = 1'b0; c_valid = 1'b0;
    step();
    chk("rr_idle_we", 32'(b_we), 32'd0);

    // out-of-range cursor write: accepted, dropped
    c_valid = 1'b1; c_x = 10'd640; c_y = 9'd0; c_col = 3'd7;
    #1;
    chk("oor_c_cready", 32'(b_cr), 32'd1);
    step();
    chk("oor_c_we",   32'(b_we), 32'd0);
    chk("oor_c_addr", 32'(b_addr), fa(3, 4));
`ifdef FB_ARB_DROP_CNT_EN
    chk("oor_c_drops", 32'(b_drops), 32'd1);
`endif
    c_valid = 1'b0;

    // out-of-range plotter (y=480) still advances the pointer, so cursor wins next tie
    p_valid = 1'b1; p_x = 10'd0; p_y = 9'd480; p_col = 3'd4;
    #1;
    chk("oor_p_pready", 32'(b_pr), 32'd1);
    step();
    chk("oor_p_we", 32'(b_we), 32'd0);
    p_x = 10'd639; p_y = 9'd479; p_col = 3'd4;
    c_valid = 1'b1; c_x = 10'd639; c_y = 9'd479; c_col = 3'd6;
    #1;
    chk("ptr_pready", 32'(b_pr), 32'd0);
    chk("ptr_cready", 32'(b_cr), 32'd1);
    step();
    chk("edge_we",   32'(b_we), 32'd1);
    chk("edge_addr", 32'(b_addr), fa(639, 479));
    chk("edge_data", 32'(b_data), 32'd6);
`ifdef FB_ARB_DROP_CNT_EN
    chk("edge_drops", 32'(b_drops), 32'd2);
`endif
    p_valid = 1'b0; c_valid = 1'b0;
    step();

    // clear sweep on the 4x2 instance, with a mid-sweep re-request
    p_valid = 1'b1; p_x = 10'd1; p_y = 9'd0; p_col = 3'd3;
    c_valid = 1'b1; c_x = 10'd2; c_y = 9'd1; c_col = 3'd5;
    clr_s = 1'b1;
    #1;
    chk("clr_req_pready", 32'(s_pr), 32'd0);
    chk("clr_req_cready", 32'(s_cr), 32'd0);
    step();
    clr_s = 1'b0;
    chk("clr_start_busy", 32'(s_busy), 32'd1);
    chk("clr_start_we",   32'(s_we), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("clr_pready", 32'(s_pr), 32'd0);
      chk("clr_cready", 32'(s_cr), 32'd0);
      step();
      chk("clr_we",   32'(s_we), 32'd1);
      chk("clr_addr", 32'(s_addr), fa(k / 2, k % 2));
      chk("clr_data", 32'(s_data), 32'd0);
      chk("clr_busy", 32'(s_busy), (k < 7) ? 32'd1 : 32'd0);
      if (k == 2) clr_s = 1'b1;
      if (k == 3) clr_s = 1'b0;
    end
    p_valid = 1'b0; c_valid = 1'b0;
    step();
    chk("clr_done_we",   32'(s_we), 32'd0);
    chk("clr_done_busy", 32'(s_busy), 32'd0);

    // reset after the 3rd clear write aborts the sweep
    clr_s = 1'b1;
    step();
    clr_s = 1'b0;
    step(); step(); step();
    chk("abort_pre_addr", 32'(s_addr), fa(1, 0));
    rst_n = 1'b0;
    #1;
    chk("abort_we",   32'(s_we), 32'd0);
    chk("abort_busy", 32'(s_busy), 32'd0);
    chk("abort_addr", 32'(s_addr), 32'd0);
    rst_n = 1'b1;
    step();
    chk("abort_rel_we",   32'(s_we), 32'd0);
    chk("abort_rel_busy", 32'(s_busy), 32'd0);
    p_valid = 1'b1; p_x = 10'd2; p_y = 9'd1; p_col = 3'd3;
    c_valid = 1'b1; c_x = 10'd3; c_y = 9'd0; c_col = 3'd5;
    #1;
    chk("abort_pready", 32'(s_pr), 32'd1);
    chk("abort_cready", 32'(s_cr), 32'd0);
    step();
    chk("abort_wr_we",   32'(s_we), 32'd1);
    chk("abort_wr_addr", 32'(s_addr), fa(2, 1));
    chk("abort_wr_data", 32'(s_data), 32'd3);
    p_valid = 1'b0; c_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
